// File: rtl/button_arbiter.sv
// Collects one debounced button press per arm request, with timeout, lowest-index
// tie-break, held-button rejection and a lamp that follows the captured button.
module button_arbiter #(
  parameter int NBTN      = 4,
  parameter int TO_CYCLES = 300_000_000,
  localparam int IW       = $clog2(NBTN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn,
  input  logic            arm,
  output logic            press_valid,
  output logic [IW-1:0]   press_idx,
  input  logic            press_ready,
  output logic            timeout,
  output logic [NBTN-1:0] lamp,
  output logic            busy
);

  localparam int            CW       = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIET   = 3'd1,
    LISTEN  = 3'd2,
    REPORT  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [NBTN-1:0] btn_prev;
  logic [NBTN-1:0] rise;
  logic            waiting;
  logic            terminal;
  logic            capture;
  logic            expire;

  function automatic logic [IW-1:0] lowest_set(input logic [NBTN-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  assign rise     = btn & ~btn_prev;
  assign waiting  = (state == QUIET) || (state == LISTEN);
  assign terminal = (cnt == CNT_LAST);
  assign capture  = (state == LISTEN) && (rise != '0);
  // A capture on the terminal-count cycle takes priority over the timeout.
  assign expire   = waiting && terminal && !capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = QUIET;
      QUIET: begin
        if (expire)          state_next = IDLE;
        else if (btn == '0)  state_next = LISTEN;
      end
      LISTEN: begin
        if (capture)         state_next = REPORT;
        else if (expire)     state_next = IDLE;
      end
      REPORT:  if (press_ready) state_next = RELEASE;
      RELEASE: if (btn == '0)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      btn_prev  <= '0;
      press_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      btn_prev <= btn;
      timeout  <= expire;
      if (state == IDLE && arm) begin
        cnt <= '0;
      end else if (waiting && !terminal) begin
        cnt <= cnt + CW'(1);
      end
      if (capture) begin
        press_idx <= lowest_set(rise);
      end
    end
  end

  always_comb begin
    press_valid = 1'b0;
    lamp        = '0;
    busy        = (state != IDLE);
    case (state)
      REPORT: begin
        press_valid = 1'b1;
        lamp        = NBTN'(1) << press_idx;
      end
      RELEASE: lamp = NBTN'(1) << press_idx;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_button_arbiter.sv
// Bench for button_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the press/timeout rules.
module tb_button_arbiter;

  localparam int NBTN = 4;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic       arm = 1'b0;
  logic       press_ready = 1'b0;
  logic       press_valid;
  logic [1:0] press_idx;
  logic       timeout;
  logic [3:0] lamp;
  logic       busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] model_idx = 2'd0;

  button_arbiter #(.NBTN(NBTN), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .arm(arm),
    .press_valid(press_valid), .press_idx(press_idx), .press_ready(press_ready),
    .timeout(timeout), .lamp(lamp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b1; btn = 4'hF; press_ready = 1'b1;
    #2;
    n_cmp++;
    if ({press_valid, press_idx, timeout, lamp, busy} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_async: pv=%b idx=%0d to=%b lamp=%b busy=%b, required all 0",
               press_valid, press_idx, timeout, lamp, busy);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({press_valid, press_idx, timeout, lamp, busy} !== 9'd0) begin
        n_bad++;
        $display("FAIL reset_held: pv=%b idx=%0d to=%b lamp=%b busy=%b, required all 0",
                 press_valid, press_idx, timeout, lamp, busy);
      end
    end
    arm = 1'b0; btn = '0; press_ready = 1'b0;
    rst_n = 1'b1;
    model_idx = 2'd0;
    step();
  endtask

  task automatic test_basic();
    logic       e_pv, e_busy;
    logic [3:0] e_lamp;
    press_ready = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      arm = (k == 0);
      btn = (k >= 5 && k < 9) ? 4'b0100 : 4'b0000;
      if (k == 6) model_idx = 2'd2;
      e_pv   = (k == 6);
      e_lamp = (k >= 6 && k <= 9) ? 4'b0100 : 4'b0000;
      e_busy = (k >= 1 && k <= 9);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, 1'b0, model_idx}) begin
        n_bad++;
        $display("FAIL basic k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=0 idx=%0d",
                 k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, model_idx);
      end
      step();
    end
    press_ready = 1'b0; arm = 1'b0; btn = '0;
  endtask

  task automatic test_simultaneous();
    logic       e_pv, e_busy;
    logic [3:0] e_lamp;
    for (int k = 0; k <= 12; k++) begin
      arm = (k == 0);
      btn = (k < 3) ? 4'b0000 : (k < 7) ? 4'b1010 : (k < 10) ? 4'b1000 : 4'b0000;
      press_ready = (k == 4);
      if (k == 4) model_idx = 2'd1;
      e_pv   = (k == 4);
      e_lamp = (k >= 4 && k <= 10) ? 4'b0010 : 4'b0000;
      e_busy = (k >= 1 && k <= 10);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, 1'b0, model_idx}) begin
        n_bad++;
        $display("FAIL simultaneous k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=0 idx=%0d",
                 k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, model_idx);
      end
      step();
    end
    press_ready = 1'b0; arm = 1'b0; btn = '0;
  endtask

  task automatic test_held_before_arm();
    logic       e_pv, e_busy;
    logic [3:0] e_lamp;
    btn = 4'b0001;
    step();
    for (int k = 0; k <= 11; k++) begin
      arm = (k == 0);
      btn = (k < 4) ? 4'b0001 : (k >= 7 && k < 9) ? 4'b1000 : 4'b0000;
      press_ready = (k == 8);
      if (k == 8) model_idx = 2'd3;
      e_pv   = (k == 8);
      e_lamp = (k >= 8 && k <= 9) ? 4'b1000 : 4'b0000;
      e_busy = (k >= 1 && k <= 9);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, 1'b0, model_idx}) begin
        n_bad++;
        $display("FAIL held_before_arm k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=0 idx=%0d",
                 k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, model_idx);
      end
      step();
    end
    press_ready = 1'b0; arm = 1'b0; btn = '0;
  endtask

  // Arm at 0 with no press; stray arms while busy are ignored, and an arm on
  // the timeout cycle starts a second wait that also expires.
  task automatic test_timeout();
    logic e_to, e_busy;
    for (int k = 0; k <= 35; k++) begin
      arm = (k == 0 || k == 5 || k == 9 || k == 17 || k == 22);
      btn = '0;
      press_ready = (k % 3 == 0);
      e_to   = (k == TO + 1) || (k == 2 * TO + 2);
      e_busy = (k >= 1 && k <= TO) || (k >= TO + 2 && k <= 2 * TO + 1);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout} !== {1'b0, 4'b0000, e_busy, e_to}) begin
        n_bad++;
        $display("FAIL timeout k=%0d: pv=%b lamp=%b busy=%b to=%b, required pv=0 lamp=0000 busy=%b to=%b",
                 k, press_valid, lamp, busy, timeout, e_busy, e_to);
      end
      step();
    end
    press_ready = 1'b0; arm = 1'b0;
  endtask

  task automatic test_timeout_race();
    logic       e_pv, e_busy;
    logic [3:0] e_lamp;
    for (int k = 0; k <= 20; k++) begin
      arm = (k == 0);
      btn = (k >= TO && k < TO + 2) ? 4'b0100 : 4'b0000;
      press_ready = (k == TO + 1);
      if (k == TO + 1) model_idx = 2'd2;
      e_pv   = (k == TO + 1);
      e_lamp = (k >= TO + 1 && k <= TO + 2) ? 4'b0100 : 4'b0000;
      e_busy = (k >= 1 && k <= TO + 2);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, 1'b0, model_idx}) begin
        n_bad++;
        $display("FAIL timeout_race k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=0 idx=%0d",
                 k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, model_idx);
      end
      step();
    end
    press_ready = 1'b0; arm = 1'b0; btn = '0;
  endtask

  task automatic test_backpressure_reset();
    logic       e_pv, e_busy;
    logic [3:0] e_lamp;
    press_ready = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      arm = (k == 0 || k == 6 || k == 9 || k == 12);
      btn = (k < 4) ? 4'b0000 : (k < 7) ? 4'b0010 : 4'b1011;
      if (k == 5) model_idx = 2'd1;
      e_pv   = (k >= 5);
      e_lamp = (k >= 5) ? 4'b0010 : 4'b0000;
      e_busy = (k >= 1);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, 1'b0, model_idx}) begin
        n_bad++;
        $display("FAIL backpressure k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=0 idx=%0d",
                 k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, model_idx);
      end
      if (k < 15) step();
    end
    rst_n = 1'b0;
    #1;
    model_idx = 2'd0;
    n_cmp++;
    if ({press_valid, press_idx, timeout, lamp, busy} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_midop: pv=%b idx=%0d to=%b lamp=%b busy=%b, required all 0",
               press_valid, press_idx, timeout, lamp, busy);
    end
    arm = 1'b0; btn = '0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k <= 7; k++) begin
      arm = (k == 0);
      btn = (k == 3 || k == 4) ? 4'b1000 : 4'b0000;
      press_ready = (k == 4);
      if (k == 4) model_idx = 2'd3;
      e_pv   = (k == 4);
      e_lamp = (k >= 4 && k <= 5) ? 4'b1000 : 4'b0000;
      e_busy = (k >= 1 && k <= 5);
      n_cmp++;
      if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, 1'b0, model_idx}) begin
        n_bad++;
        $display("FAIL restart k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=0 idx=%0d",
                 k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, model_idx);
      end
      step();
    end
    press_ready = 1'b0; arm = 1'b0; btn = '0;
  endtask

  // Each transaction is planned up front; the expected waveform follows from
  // when the player's first fresh press lands relative to the timeout window.
  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [3:0] held, press, e_lamp;
      logic       e_pv, e_busy, e_to;
      int         hold_len, quiet_end, p, r, rel, idle_c, last_c, q;
      bit         has_press, cap;
      held      = ($urandom % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      hold_len  = $urandom_range(1, 4);
      has_press = ($urandom % 5) != 0;
      press     = 4'($urandom_range(1, 15));
      quiet_end = (held != 0) ? hold_len + 1 : 1;
      p         = quiet_end + 1 + $urandom_range(0, 14);
      cap       = has_press && (p <= TO);
      r         = p + 1 + $urandom_range(0, 3);
      rel       = p + 1 + $urandom_range(0, 6);
      q         = (rel > r + 1) ? rel : r + 1;
      idle_c    = cap ? q + 1 : TO + 1;
      last_c    = ((idle_c > rel) ? idle_c : rel) + 1;
      for (int k = 0; k <= last_c; k++) begin
        arm = (k == 0) || (k < idle_c && ($urandom % 4 == 0));
        if (held != 0 && k <= hold_len)          btn = held;
        else if (has_press && k >= p && k < rel) btn = press;
        else                                     btn = 4'h0;
        if (cap && k >= p + 1 && k < r) press_ready = 1'b0;
        else if (cap && k == r)         press_ready = 1'b1;
        else                            press_ready = 1'($urandom % 2);
        if (cap && k == p + 1) model_idx = low_idx(press);
        e_pv   = cap && k >= p + 1 && k <= r;
        e_lamp = (cap && k >= p + 1 && k < idle_c) ? (4'b0001 << model_idx) : 4'b0000;
        e_busy = (k >= 1 && k < idle_c);
        e_to   = !cap && (k == TO + 1);
        n_cmp++;
        if ({press_valid, lamp, busy, timeout, press_idx} !== {e_pv, e_lamp, e_busy, e_to, model_idx}) begin
          n_bad++;
          $display("FAIL random it=%0d k=%0d: pv=%b lamp=%b busy=%b to=%b idx=%0d, required pv=%b lamp=%b busy=%b to=%b idx=%0d",
                   it, k, press_valid, lamp, busy, timeout, press_idx, e_pv, e_lamp, e_busy, e_to, model_idx);
        end
        step();
      end
      arm = 1'b0; btn = '0; press_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_held_before_arm();
    test_timeout();
    test_timeout_race();
    test_backpressure_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
